// File: rtl/layer1_drain.sv
// ---------------------------------------------------------------------------
// layer1_drain
//
// Captures one finished 10-lane accumulation column and streams it out as ten
// 16-bit words with a valid/ready handshake. Each word carries its flat address
// col_idx*10 + lane. After the last word of column NUM_COLS-1 is accepted, a
// one-cycle done pulse closes the layer pass and the column index wraps to 0.
//
// Parameters
//   NUM_COLS  columns per layer pass (1..102)
//   ADDR_W    output address width (NUM_COLS*10 <= 2**ADDR_W)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   column     ten 16-bit two's-complement lanes, lane k = column[16k+15:16k]
//   col_valid  column holds a finished accumulation
//   col_ready  block can capture a column (IDLE)
//   out_data   current output word
//   out_addr   word address col_idx*10 + lane
//   out_valid  out_data/out_addr valid (DRAIN)
//   out_ready  downstream accepts the word this cycle
//   done       one-cycle pulse after the final word of the pass is accepted
//
// Build option
//   LAYER1_DRAIN_RELU_EN  when defined, negative lanes are output as 16'h0000.
//                         Timing, handshake and addressing are unaffected.
// ---------------------------------------------------------------------------
module layer1_drain #(
    parameter int NUM_COLS = 32,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [159:0]      column,
    input  logic              col_valid,
    output logic              col_ready,
    output logic [15:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [3:0]        LANE_LAST = 4'd9;
    localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(NUM_COLS - 1);

    state_e              state_q,     state_d;
    logic [3:0]          lane_q,      lane_d;
    logic [ADDR_W-1:0]   col_idx_q,   col_idx_d;
    logic [159:0]        buf_q,       buf_d;
    logic                col_ready_q, col_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                done_q,      done_d;

    logic [15:0]         lane_word;

    // Next-state logic. The handshake flags are computed from the state being
    // entered so that they can be registered alongside it.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; a missed branch would otherwise infer a latch.
        state_d     = state_q;
        lane_d      = lane_q;
        col_idx_d   = col_idx_q;
        buf_d       = buf_q;
        col_ready_d = col_ready_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (col_valid) begin
                    buf_d       = column;
                    lane_d      = 4'd0;
                    state_d     = DRAIN;
                    col_ready_d = 1'b0;
                    out_valid_d = 1'b1;
                end
            end

            DRAIN: begin
                if (out_ready) begin
                    if (lane_q != LANE_LAST) begin
                        lane_d = lane_q + 4'd1;
                    end else if (col_idx_q != COL_LAST) begin
                        col_idx_d   = col_idx_q + ADDR_W'(1);
                        state_d     = IDLE;
                        col_ready_d = 1'b1;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d     = DONE;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end

            DONE: begin
                col_idx_d   = '0;
                state_d     = IDLE;
                col_ready_d = 1'b1;
            end

            default: begin
                state_d     = IDLE;
                col_ready_d = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: the column buffer is reset along with the control state so that
    // out_data reads 0 straight out of reset and an aborted column is wiped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lane_q      <= 4'd0;
            col_idx_q   <= '0;
            buf_q       <= '0;
            col_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            lane_q      <= lane_d;
            col_idx_q   <= col_idx_d;
            buf_q       <= buf_d;
            col_ready_q <= col_ready_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // Lane select straight from the held buffer: data and address only move
    // when lane_q/col_idx_q move, i.e. on an accepted transfer.
    assign lane_word = buf_q[{lane_q, 4'b0000} +: 16];

`ifdef LAYER1_DRAIN_RELU_EN
    assign out_data = lane_word[15] ? 16'h0000 : lane_word;
`else
    assign out_data = lane_word;
`endif

    assign out_addr  = col_idx_q * ADDR_W'(10) + ADDR_W'(lane_q);
    assign col_ready = col_ready_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_layer1_drain.sv
// ---------------------------------------------------------------------------
// tb_layer1_drain
//
// Scoreboard bench for layer1_drain with NUM_COLS=2, ADDR_W=5. Stimulus pushes
// the expected {address, data} of every word it provokes; a negedge monitor
// pops and compares whenever a word is transferred. Control outputs (done,
// col_ready, out_valid, stall hold values) are checked directly by stimulus.
// ---------------------------------------------------------------------------
module tb_layer1_drain;

    localparam int NUM_COLS = 2;
    localparam int ADDR_W   = 5;

    logic              clk;
    logic              reset;
    logic [159:0]      column;
    logic              col_valid;
    logic              col_ready;
    logic [15:0]       out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_valid;
    logic              out_ready;
    logic              done;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    layer1_drain #(
        .NUM_COLS (NUM_COLS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .column    (column),
        .col_valid (col_valid),
        .col_ready (col_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every transferred word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            check("done_with_valid", 32'(done & out_valid), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word got addr=%0d data=%h expected no word", out_addr, out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word_addr", 32'(out_addr), 32'(mon_e.addr));
                    check("word_data", 32'(out_data), 32'(mon_e.data));
                end
            end
        end
    end

    // Called in IDLE one tick after an edge; captures and pushes the first
    // npush expected words starting at base_addr.
    task automatic run_capture(input logic [15:0] lanes[10], input logic [15:0] exp_data[10],
                               input int base_addr, input int npush);
        exp_t e;
        check("cap_col_ready", 32'(col_ready), 32'd1);
        for (int k = 0; k < 10; k++) column[16*k +: 16] = lanes[k];
        col_valid = 1'b1;
        for (int k = 0; k < npush; k++) begin
            e.addr = ADDR_W'(base_addr + k);
            e.data = exp_data[k];
            exp_q.push_back(e);
        end
        tick();
        col_valid = 1'b0;
        check("cap_out_valid_next", 32'(out_valid), 32'd1);
        check("cap_col_ready_low", 32'(col_ready), 32'd0);
    endtask

    task automatic drain_wait(output int n);
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("drain_complete", 32'(exp_q.size()), 32'd0);
    endtask

    logic [15:0] lanes[10];
    logic [15:0] expd[10];
    int          n;

    initial begin
        reset     = 1'b1;
        col_valid = 1'b0;
        out_ready = 1'b1;
        column    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_col_ready", 32'(col_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_addr",  32'(out_addr),  32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_col_ready", 32'(col_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_out_data",  32'(out_data),  32'd0);

        // Column 0: lanes 1..10, ten consecutive words at addresses 0..9.
        for (int k = 0; k < 10; k++) begin lanes[k] = 16'(k + 1); expd[k] = lanes[k]; end
        run_capture(lanes, expd, 0, 10);
        drain_wait(n);
        check("s1_consecutive_cycles", 32'(n), 32'd10);
        check("s1_col_ready_back", 32'(col_ready), 32'd1);
        check("s1_no_done", 32'(done), 32'd0);

        // Column 1: all lanes 0x0100 at addresses 10..19, then the done pulse.
        for (int k = 0; k < 10; k++) begin lanes[k] = 16'h0100; expd[k] = 16'h0100; end
        run_capture(lanes, expd, 10, 10);
        drain_wait(n);
        check("s2_done_pulse", 32'(done), 32'd1);
        check("s2_done_no_valid", 32'(out_valid), 32'd0);
        check("s2_done_col_ready", 32'(col_ready), 32'd0);
        tick();
        check("s2_done_one_cycle", 32'(done), 32'd0);
        check("s2_idle_col_ready", 32'(col_ready), 32'd1);

        // New pass, column 0 with a 3-cycle stall at lane 4.
        for (int k = 0; k < 10; k++) begin lanes[k] = 16'(16'h0020 + k); expd[k] = lanes[k]; end
        run_capture(lanes, expd, 0, 10);
        repeat (4) tick();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check("s3_hold_addr",  32'(out_addr),  32'd4);
            check("s3_hold_data",  32'(out_data),  32'h0024);
            check("s3_hold_valid", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        drain_wait(n);
        check("s3_col_ready_back", 32'(col_ready), 32'd1);

        // Column 1: negative lane 2, col_valid held with other data while draining.
        for (int k = 0; k < 10; k++) begin lanes[k] = 16'(16'h0030 + k); expd[k] = lanes[k]; end
        lanes[2] = 16'hFFF6;
`ifdef LAYER1_DRAIN_RELU_EN
        expd[2] = 16'h0000;
`else
        expd[2] = 16'hFFF6;
`endif
        run_capture(lanes, expd, 10, 10);
        column    = {10{16'h7777}};
        col_valid = 1'b1;
        drain_wait(n);
        check("s4_done_pulse", 32'(done), 32'd1);
        col_valid = 1'b0;
        tick();
        check("s4_done_cleared", 32'(done), 32'd0);
        check("s4_col_ready", 32'(col_ready), 32'd1);
        tick();
        check("s4_no_spurious_capture", 32'(out_valid), 32'd0);

        // Reset at lane 6 of column 1.
        for (int k = 0; k < 10; k++) begin lanes[k] = 16'(16'h0040 + k); expd[k] = lanes[k]; end
        run_capture(lanes, expd, 0, 10);
        drain_wait(n);
        for (int k = 0; k < 10; k++) begin lanes[k] = 16'(16'h0050 + k); expd[k] = lanes[k]; end
        run_capture(lanes, expd, 10, 6);
        repeat (6) tick();
        check("s5_at_lane6_addr", 32'(out_addr), 32'd16);
        reset = 1'b1;
        #1;
        check("s5_rst_out_valid", 32'(out_valid), 32'd0);
        check("s5_rst_col_ready", 32'(col_ready), 32'd1);
        check("s5_rst_done",      32'(done),      32'd0);
        for (int s = 0; s < 2; s++) begin
            tick();
            check("s5_rst_no_done", 32'(done), 32'd0);
        end
        reset = 1'b0;
        tick();
        check("s5_after_rst_no_done", 32'(done), 32'd0);
        for (int k = 0; k < 10; k++) begin lanes[k] = 16'(16'h0060 + k); expd[k] = lanes[k]; end
        run_capture(lanes, expd, 0, 10);
        drain_wait(n);
        check("s5_col_ready_back", 32'(col_ready), 32'd1);
        check("s5_no_done_col0", 32'(done), 32'd0);

        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog_timeout got=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/layer1_drain.md
LAYER1_DRAIN -- requirements
Module: layer1_drain

Interface
REQ-001 Parameter NUM_COLS, default 32: columns per layer pass, range 1..102.
REQ-002 Parameter ADDR_W, default 10: output address width; NUM_COLS*10 SHALL be at most 2^ADDR_W.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 column  input  160  ten 16-bit two's-complement lane results; lane k = column[16k+15:16k].
REQ-006 col_valid  input  1  column holds a finished accumulation.
REQ-007 col_ready  output  1  block can capture a column.
REQ-008 out_data  output  16  current output word.
REQ-009 out_addr  output  ADDR_W  word address: col_idx*10 + lane.
REQ-010 out_valid  output  1  out_data/out_addr are valid.
REQ-011 out_ready  input  1  downstream accepts the word this cycle.
REQ-012 done  output  1  one-cycle pulse after the last word of column NUM_COLS-1 is accepted.

Function
REQ-013 FSM states are IDLE, DRAIN and DONE.
REQ-014 IDLE: col_ready=1, out_valid=0; capture on col_valid=1 at a rising edge: all 160 bits into the internal buffer, lane=0, next state DRAIN.
REQ-015 DRAIN: col_ready=0, out_valid=1, out_data = processed buffer lane, out_addr = col_idx*10+lane.
REQ-016 A word is transferred only on a cycle with out_valid=1 and out_ready=1; without that, out_data and out_addr SHALL hold stable.
REQ-017 On transfer with lane<9: lane increments by 1 and the state stays DRAIN.
REQ-018 On transfer with lane=9 and col_idx<NUM_COLS-1: col_idx increments and the state goes to IDLE.
REQ-019 On transfer with lane=9 and col_idx=NUM_COLS-1: the state goes to DONE.
REQ-020 DONE lasts exactly one cycle: done=1, col_ready=0, out_valid=0, col_idx cleared to 0, next state IDLE.
REQ-021 col_valid while col_ready=0 is ignored; no capture and no side effect.
REQ-022 Minimum per-column latency is 1 capture cycle plus 10 transfer cycles; out_valid asserts the cycle after capture.
REQ-023 The column input is sampled only at capture; later changes to column do not affect the words being drained.
REQ-024 out_ready toggling mid-column SHALL NOT skip or duplicate a lane.
REQ-025 done and out_valid are never asserted in the same cycle.

Reset
REQ-026 Reset asynchronously sets: state IDLE, lane 0, col_idx 0, buffer 0.
REQ-027 Outputs during and right after reset: col_ready=1, out_valid=0, done=0, out_data=0, out_addr=0.
REQ-028 Reset mid-DRAIN discards the buffered column; no done pulse is generated for the aborted pass.

Configuration
REQ-029 With macro LAYER1_DRAIN_RELU_EN defined: a lane with bit 15 = 1 outputs 16'h0000; other lanes pass unchanged.
REQ-030 Without LAYER1_DRAIN_RELU_EN: out_data equals the buffered lane bit-exactly, negatives included.
REQ-031 The macro SHALL NOT change timing, handshake or addressing.

Verification
REQ-032 Scenario: NUM_COLS=2, out_ready=1, column lanes 0..9 = 1..10, capture -> ten words 1..10 on consecutive cycles at addresses 0..9; col_ready returns to 1 the next cycle.
REQ-033 Scenario: second column, lanes = 16'h0100 -> addresses 10..19; done=1 exactly one cycle after address 19 is accepted; the next capture uses address 0.
REQ-034 Scenario: out_ready low for 3 cycles at lane 4 -> out_data and out_addr held at lane 4 and address 4; no lane lost or repeated.
REQ-035 Scenario: lane 2 = 16'hFFF6 (-10) -> output 16'h0000 with RELU_EN, 16'hFFF6 without.
REQ-036 Scenario: col_valid held high during DRAIN with a different column value -> ignored; the drained words match the first capture.
REQ-037 Scenario: reset asserted at lane 6 of column 1 -> immediately out_valid=0, col_ready=1, no done; the next capture drains at address 0.
